cacheline_adaptor: RTL and testbench
====================================

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL have parameter BURST_W, default 64, meaning bits per memory beat.
REQ-002 SHALL have parameter BURST_LEN, default 4, meaning beats per cache line.
REQ-003 SHALL have parameter ADDR_W, default 32, meaning address width; LINE_W = BURST_W*BURST_LEN (256).
REQ-004 SHALL have port clk  in  1  clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset; one clock, reset asynchronous and active-low (asserted at 0).
REQ-006 SHALL have cache-side ports: line_i in LINE_W write line; line_o out LINE_W read line; address_i in ADDR_W request address; read_i in 1; write_i in 1; resp_o out 1 done pulse.
REQ-007 SHALL have memory-side ports: burst_i in BURST_W read beat; burst_o out BURST_W write beat; address_o out ADDR_W line address; read_o out 1; write_o out 1; resp_i in 1 beat accept/valid.

Function
REQ-008 SHALL implement states IDLE, READ, WRITE, DONE with a beat counter of $clog2(BURST_LEN) bits.
REQ-009 SHALL sample read_i/write_i only in IDLE; read_i has priority when both high.
REQ-010 On accept SHALL latch address_i with low $clog2(LINE_W/8) bits (5) cleared, latch line_i on write, clear counter, go READ or WRITE.
REQ-011 SHALL drive address_o from the latched address, stable for the whole transaction; read_o=1 only in READ, write_o=1 only in WRITE (registered; first asserted one cycle after accept).
REQ-012 In READ, each cycle with resp_i=1 SHALL store burst_i into beat slot [counter] (beat 0 = bits 63:0) and increment counter; resp_i=0 holds everything.
REQ-013 In WRITE, burst_o SHALL equal latched line beat [counter]; each resp_i=1 advances counter.
REQ-014 On the BURST_LEN-th accepted beat SHALL deassert read_o/write_o next cycle and enter DONE.
REQ-015 In DONE SHALL assert resp_o for exactly one cycle, then return to IDLE; line_o valid from that cycle onward.
REQ-016 line_o SHALL hold the last completed read line until the next read completes; partial reads never alter line_o.
REQ-017 resp_i in IDLE or DONE SHALL be ignored; requestor must drop read_i/write_i the cycle after resp_o, else a new transaction starts.
REQ-018 Counter SHALL wrap to 0 after the last beat; no extra beats consumed.

Reset
REQ-019 rst=0 SHALL immediately force IDLE, counter 0, read_o=0, write_o=0, resp_o=0, address_o=0, burst_o=0, line_o=0, including mid-transaction; partial data discarded.

Configuration
REQ-020 Macro CACHELINE_ADAPTOR_ASSERT_EN defined: SHALL compile concurrent assertions (no resp_i outside READ/WRITE; read_o&&write_o never both 1; address_o stable while read_o|write_o; resp_o one cycle wide); failures call $error.
REQ-021 Macro undefined: no assertions; functional behaviour identical.

Structure
REQ-022 BURST_W, BURST_LEN, LINE_W constants and the state enum SHALL live in shared package cache_mem_types, imported by this block and the cache.
REQ-023 SHALL be a single module; no sub-module.

Verification
REQ-024 Read: address_i=0x0000_1234, read_i=1; resp_i 4 consecutive beats 0x0..0A,0x..0B,0x..0C,0x..0D -> address_o=0x0000_1220, read_o drops after beat 4, resp_o 1 cycle, line_o={D,C,B,A}.
REQ-025 Write: line_i=256'h4444..._3333..._2222..._1111..., write_i=1; resp_i pattern 1,0,1,1,0,1 -> burst_o 0x1111..,0x2222..,0x3333..,0x4444.. in order, advancing only on resp_i=1, resp_o once.
REQ-026 Reset mid-read: rst=0 after 2 beats -> all outputs 0 same cycle; after release a full read completes with correct line_o.
REQ-027 read_i=1 and write_i=1 together -> read transaction only, write_o never asserted.
REQ-028 Back-to-back: read then write issued the cycle after resp_o -> second transaction address_o latched fresh, no beat lost or duplicated; stray resp_i in IDLE ignored.

Source files
------------

// File: rtl/cache_mem_types.sv
// Shared cache/memory constants and the adaptor state encoding.
// Imported by cacheline_adaptor and by the cache that drives it.
package cache_mem_types;

    localparam int BURST_W   = 64;
    localparam int BURST_LEN = 4;
    localparam int LINE_W    = BURST_W * BURST_LEN;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// Purpose: splits a cache line into BURST_LEN memory beats (write) or gathers beats into a line (read).
// Latency: read_o/write_o one cycle after accept; resp_o one cycle after the last accepted beat.
// Backpressure: memory stalls the burst by holding resp_i low; CACHELINE_ADAPTOR_ASSERT_EN enables protocol checks.
module cacheline_adaptor #(
    parameter  int BURST_W   = cache_mem_types::BURST_W,
    parameter  int BURST_LEN = cache_mem_types::BURST_LEN,
    parameter  int ADDR_W    = 32,
    localparam int LINE_W    = BURST_W * BURST_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LINE_W-1:0] line_i,
    output logic [LINE_W-1:0] line_o,
    input  logic [ADDR_W-1:0] address_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic              resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0] address_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i
);

    import cache_mem_types::*;

    localparam int CNT_W = $clog2(BURST_LEN);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_W / 8 - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   wline_q;
    logic [LINE_W-1:0]   rbuf_q, rbuf_nxt;
    logic [LINE_W-1:0]   line_q;
    logic                read_q, write_q, resp_q;
    logic                accept, beat_acc, last_beat;

    assign accept    = (state_q == IDLE) && (read_i || write_i);
    assign beat_acc  = resp_i && ((state_q == READ) || (state_q == WRITE));
    assign last_beat = beat_acc && (cnt_q == CNT_W'(BURST_LEN - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (read_i)       state_d = READ;
                else if (write_i) state_d = WRITE;
            end
            READ, WRITE: begin
                if (last_beat) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Assembly buffer with the current beat merged in, so the final beat can land in line_o directly.
    always_comb begin
        rbuf_nxt = rbuf_q;
        if (beat_acc && (state_q == READ)) begin
            rbuf_nxt[cnt_q*BURST_W +: BURST_W] = burst_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rbuf_q  <= '0;
            line_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            read_q  <= (state_d == READ);
            write_q <= (state_d == WRITE);
            resp_q  <= (state_d == DONE);
            if (accept) begin
                addr_q <= address_i & ~OFF_MASK;
                cnt_q  <= '0;
                if (!read_i) begin
                    wline_q <= line_i;
                end
            end else if (beat_acc) begin
                cnt_q  <= last_beat ? '0 : cnt_q + CNT_W'(1);
                rbuf_q <= rbuf_nxt;
                if (last_beat && (state_q == READ)) begin
                    line_q <= rbuf_nxt;
                end
            end
        end
    end

    assign read_o    = read_q;
    assign write_o   = write_q;
    assign resp_o    = resp_q;
    assign address_o = addr_q;
    assign line_o    = line_q;
    assign burst_o   = write_q ? wline_q[cnt_q*BURST_W +: BURST_W] : '0;

`ifdef CACHELINE_ADAPTOR_ASSERT_EN
    a_resp_in_burst: assert property (@(posedge clk) disable iff (!rst)
        resp_i |-> ((state_q == READ) || (state_q == WRITE)))
        else $error("resp_i asserted outside a burst");

    a_rd_wr_excl: assert property (@(posedge clk) disable iff (!rst)
        !(read_o && write_o))
        else $error("read_o and write_o both high");

    a_addr_stable: assert property (@(posedge clk) disable iff (!rst)
        (read_o || write_o) ##1 (read_o || write_o) |-> $stable(address_o))
        else $error("address_o changed mid-burst");

    a_resp_pulse: assert property (@(posedge clk) disable iff (!rst)
        resp_o |=> !resp_o)
        else $error("resp_o wider than one cycle");
`else
    // Protocol checks compiled out.
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: transaction-level reference model checked every cycle,
// plus literal expectations on the headline read, write, reset and back-to-back scenarios.
module tb_cacheline_adaptor;

    localparam int BW = 64;
    localparam int LW = 256;

    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_RD   = 2'd1;
    localparam logic [1:0] M_WR   = 2'd2;
    localparam logic [1:0] M_DONE = 2'd3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [LW-1:0] line_i = '0;
    logic [LW-1:0] line_o;
    logic [31:0]   address_i = '0;
    logic          read_i = 1'b0;
    logic          write_i = 1'b0;
    logic          resp_o;
    logic [BW-1:0] burst_i = '0;
    logic [BW-1:0] burst_o;
    logic [31:0]   address_o;
    logic          read_o;
    logic          write_o;
    logic          resp_i = 1'b0;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int resp_cnt = 0;
    int wr_cycles = 0;
    logic [BW-1:0] wq[$];

    task automatic check(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: which phase we are in, how many beats have been accepted, and the data.
    typedef struct packed {
        logic [1:0]    st;
        logic [2:0]    beats;
        logic [31:0]   addr;
        logic [LW-1:0] wline;
        logic [LW-1:0] part;
        logic [LW-1:0] line;
    } mdl_t;

    mdl_t m = '0;

    function automatic mdl_t model_next(input mdl_t c, input logic rd, input logic wr,
                                        input logic [31:0] a, input logic [LW-1:0] l,
                                        input logic rsp, input logic [BW-1:0] b);
        mdl_t n = c;
        case (c.st)
            M_IDLE: if (rd || wr) begin
                n.st    = rd ? M_RD : M_WR;
                n.addr  = a - (a % 32);
                n.beats = 3'd0;
                if (!rd) n.wline = l;
            end
            M_RD: if (rsp) begin
                n.part[64*c.beats +: 64] = b;
                n.beats = c.beats + 3'd1;
                if (n.beats == 3'd4) begin
                    n.st   = M_DONE;
                    n.line = n.part;
                end
            end
            M_WR: if (rsp) begin
                n.beats = c.beats + 3'd1;
                if (n.beats == 3'd4) n.st = M_DONE;
            end
            default: n.st = M_IDLE;
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= '0;
        else      m <= model_next(m, read_i, write_i, address_i, line_i, resp_i, burst_i);
    end

    always @(negedge clk) begin
        check("cyc_read_o",    LW'(read_o),    LW'(m.st == M_RD));
        check("cyc_write_o",   LW'(write_o),   LW'(m.st == M_WR));
        check("cyc_resp_o",    LW'(resp_o),    LW'(m.st == M_DONE));
        check("cyc_address_o", LW'(address_o), LW'(m.addr));
        check("cyc_line_o",    line_o,         m.line);
        if (m.st == M_WR) check("cyc_burst_o", LW'(burst_o), LW'(m.wline[64*m.beats +: 64]));
        if (write_o && resp_i) wq.push_back(burst_o);
        if (resp_o) resp_cnt++;
        if (write_o) wr_cycles++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beats4(input logic [BW-1:0] b0, input logic [BW-1:0] b1,
                          input logic [BW-1:0] b2, input logic [BW-1:0] b3);
        logic [BW-1:0] bs[4];
        bs = '{b0, b1, b2, b3};
        for (int i = 0; i < 4; i++) begin
            resp_i  = 1'b1;
            burst_i = bs[i];
            tick();
        end
        resp_i  = 1'b0;
        burst_i = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LW-1:0] wl;
        logic [LW-1:0] wl2;
        int pat[6];

        // Reset state
        tick();
        check("rst_read_o", LW'(read_o), '0);
        check("rst_write_o", LW'(write_o), '0);
        check("rst_resp_o", LW'(resp_o), '0);
        check("rst_address_o", LW'(address_o), '0);
        check("rst_burst_o", LW'(burst_o), '0);
        check("rst_line_o", line_o, '0);
        tick();
        rst = 1'b1;
        tick();

        // Plain read of 0x1234
        resp_cnt = 0;
        address_i = 32'h0000_1234; read_i = 1'b1;
        tick();
        read_i = 1'b0; address_i = '0;
        check("rd_read_o_up", LW'(read_o), LW'(1'b1));
        check("rd_address_o", LW'(address_o), LW'(32'h0000_1220));
        beats4(64'h0A, 64'h0B, 64'h0C, 64'h0D);
        check("rd_read_o_drop", LW'(read_o), '0);
        check("rd_resp_o", LW'(resp_o), LW'(1'b1));
        check("rd_line_o", line_o, {64'h0D, 64'h0C, 64'h0B, 64'h0A});
        tick();
        check("rd_resp_o_low", LW'(resp_o), '0);
        check("rd_resp_count", LW'(resp_cnt), LW'(1));

        // Write with a stalling memory
        wl = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        line_i = wl; address_i = 32'h0000_0100; write_i = 1'b1;
        tick();
        write_i = 1'b0; line_i = '0;
        wq.delete(); resp_cnt = 0;
        check("wr_write_o_up", LW'(write_o), LW'(1'b1));
        pat = '{1, 0, 1, 1, 0, 1};
        for (int i = 0; i < 6; i++) begin
            resp_i = pat[i][0];
            tick();
        end
        resp_i = 1'b0;
        check("wr_resp_o", LW'(resp_o), LW'(1'b1));
        check("wr_write_o_drop", LW'(write_o), '0);
        tick();
        check("wr_beat_count", LW'(wq.size()), LW'(4));
        if (wq.size() == 4) begin
            check("wr_beat0", LW'(wq[0]), LW'({16{4'h1}}));
            check("wr_beat1", LW'(wq[1]), LW'({16{4'h2}}));
            check("wr_beat2", LW'(wq[2]), LW'({16{4'h3}}));
            check("wr_beat3", LW'(wq[3]), LW'({16{4'h4}}));
        end
        check("wr_resp_count", LW'(resp_cnt), LW'(1));
        check("wr_line_o_held", line_o, {64'h0D, 64'h0C, 64'h0B, 64'h0A});

        // Reset in the middle of a read
        address_i = 32'h0000_0040; read_i = 1'b1;
        tick();
        read_i = 1'b0;
        resp_i = 1'b1; burst_i = 64'hE0; tick();
        burst_i = 64'hE1; tick();
        resp_i = 1'b0; burst_i = '0;
        rst = 1'b0;
        #1;
        check("mid_rst_read_o", LW'(read_o), '0);
        check("mid_rst_address_o", LW'(address_o), '0);
        check("mid_rst_line_o", line_o, '0);
        check("mid_rst_resp_o", LW'(resp_o), '0);
        tick();
        rst = 1'b1;
        tick();
        address_i = 32'h0000_0088; read_i = 1'b1;
        tick();
        read_i = 1'b0;
        check("post_rst_address_o", LW'(address_o), LW'(32'h0000_0080));
        beats4(64'hF0, 64'hF1, 64'hF2, 64'hF3);
        check("post_rst_line_o", line_o, {64'hF3, 64'hF2, 64'hF1, 64'hF0});
        tick();

        // Read and write together: read wins
        wr_cycles = 0;
        address_i = 32'h0000_2000; line_i = {4{64'hDEAD_BEEF_0000_0001}};
        read_i = 1'b1; write_i = 1'b1;
        tick();
        read_i = 1'b0; write_i = 1'b0; line_i = '0;
        check("both_read_o", LW'(read_o), LW'(1'b1));
        beats4(64'h50, 64'h51, 64'h52, 64'h53);
        tick();
        check("both_no_write", LW'(wr_cycles), '0);
        check("both_line_o", line_o, {64'h53, 64'h52, 64'h51, 64'h50});

        // Back-to-back read then write, with stray resp_i after the read
        address_i = 32'h0000_3010; read_i = 1'b1;
        tick();
        read_i = 1'b0;
        check("b2b_rd_address_o", LW'(address_o), LW'(32'h0000_3000));
        beats4(64'h60, 64'h61, 64'h62, 64'h63);
        check("b2b_rd_resp_o", LW'(resp_o), LW'(1'b1));
        wl2 = {64'hCCCC_0003, 64'hCCCC_0002, 64'hCCCC_0001, 64'hCCCC_0000};
        address_i = 32'h0000_4567; line_i = wl2; write_i = 1'b1; resp_i = 1'b1;
        tick();
        check("b2b_idle_no_rd", LW'(read_o), '0);
        tick();
        write_i = 1'b0; line_i = '0; address_i = '0;
        wq.delete(); resp_cnt = 0;
        check("b2b_wr_address_o", LW'(address_o), LW'(32'h0000_4560));
        check("b2b_wr_write_o", LW'(write_o), LW'(1'b1));
        for (int i = 0; i < 4; i++) tick();
        resp_i = 1'b0;
        check("b2b_wr_resp_o", LW'(resp_o), LW'(1'b1));
        tick();
        tick();
        check("b2b_wr_beat_count", LW'(wq.size()), LW'(4));
        if (wq.size() == 4) begin
            check("b2b_wr_beat0", LW'(wq[0]), LW'(64'hCCCC_0000));
            check("b2b_wr_beat3", LW'(wq[3]), LW'(64'hCCCC_0003));
        end
        check("b2b_resp_count", LW'(resp_cnt), LW'(1));
        check("b2b_line_o", line_o, {64'h63, 64'h62, 64'h61, 64'h60});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
